stream_tx_scheduler: RTL
========================

// Module: stream_tx_scheduler
// PURPOSE
// - Round-robin scheduler that drains per-sensor byte FIFOs into the shared UART transmitter.
// - Streams enabled by the stream_select mask; sending gated by ds_sending_flag (both from the app-command handler).
// - One byte per grant; one FIFO read and one UART transaction in flight at a time.
// PARAMETERS
// - NUM_STREAMS  8    number of sensor FIFOs; also stream_select and fifo_rd width; index width 3.
// - TX_TIMEOUT   1023 cycles to wait for uart_tx_done before abandoning a byte; 10-bit counter.
// PORTS
// - clock            in   1   system clock; all state on posedge.
// - resetn           in   1   asynchronous, active-low reset.
// - ds_sending_flag  in   1   1 = streaming enabled.
// - stream_select    in   8   bit i = stream i enabled.
// - fifo_empty       in   8   bit i = FIFO i empty.
// - fifo_data        in   64  FIFO i read data on bits [8i+7:8i]; valid the cycle after fifo_rd[i].
// - fifo_rd          out  8   one-hot, one-cycle read strobe.
// - uart_tx_ready    in   1   transmitter idle; may accept a byte.
// - uart_tx_done     in   1   one-cycle pulse; byte fully shifted out.
// - uart_tx_start    out  1   one-cycle pulse; transmitter latches uart_tx_byte.
// - uart_tx_byte     out  8   byte to transmit; held stable from start until done or timeout.
// - current_stream   out  3   index of the stream being served.
// - busy             out  1   1 in every state except IDLE.
// - tx_timeout_err   out  1   sticky; set on timeout; cleared only by reset.
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE; last_served=7, so stream 0 is served first; all outputs 0.
// - eligible = stream_select & ~fifo_empty; evaluated combinationally in IDLE only.
// - IDLE: ds_sending_flag & |eligible -> SELECT; otherwise stay in IDLE.
// - SELECT: idx = first set eligible bit searching last_served+1 .. last_served+NUM_STREAMS.
//   - Search is modulo NUM_STREAMS; wraps 7->0.
//   - Latch idx and drive current_stream=idx.
//   - If eligible has become 0 -> IDLE.
// - READ: fifo_rd[idx]=1 for exactly one cycle -> CAPTURE.
// - CAPTURE: uart_tx_byte <= fifo_data[8*idx+:8] -> SEND (or HDR_SEND if STREAM_HEADER_EN).
// - SEND: wait for uart_tx_ready; in that cycle pulse uart_tx_start; clear timer -> WAIT_DONE.
// - WAIT_DONE: timer increments each cycle.
//   - uart_tx_done -> last_served<=idx -> IDLE.
//   - timer==TX_TIMEOUT-1 without done -> tx_timeout_err<=1; last_served<=idx -> IDLE.
//   - done and expiry in the same cycle: done wins; no error.
// - Latency, IDLE to uart_tx_start with ready high = 4 cycles (SELECT, READ, CAPTURE, SEND).
// - ds_sending_flag falls mid-transaction:
//   - SELECT: abort to IDLE with no read.
//   - Any state after READ: finish the byte (data already popped), then IDLE.
// - stream_select or fifo_empty changes after SELECT: ignored for the current byte.
// - Exactly one eligible stream: served back-to-back.
// - Fairness: after serving i, every other eligible stream is served before i again.
// - fifo_rd is never asserted for an empty or deselected FIFO; at most one fifo_rd bit is high.
// - uart_tx_start is never asserted while uart_tx_ready=0.
// - resetn low in any state: immediate return to reset values; in-flight byte dropped.
// CONFIGURATION
// - STREAM_HEADER_EN defined:
//   - CAPTURE -> HDR_SEND, which sends header {5'b10100, idx} using the same ready/start/done/timeout rules (HDR_WAIT).
//   - After header done -> SEND with the data byte.
//   - Header timeout: set err, drop the data byte, -> IDLE.
//   - Latency to first start unchanged; data byte follows header done.
// - STREAM_HEADER_EN undefined: data bytes only; HDR states absent.
// TESTING
// - Reset: resetn=0 mid-WAIT_DONE -> all outputs 0, busy=0; next grant goes to stream 0.
// - Round robin: select=8'h25, all FIFOs non-empty, done 10 cycles after each start -> fifo_rd order 0,2,5,0,2,5.
// - Gating: flag=0, select=8'hFF, FIFOs full -> no fifo_rd for 100 cycles; flag=1 -> fifo_rd=8'h01 on the 2nd cycle after flag rises (SELECT then READ).
// - Flag drop: drop flag the cycle after fifo_rd -> byte still started; after uart_tx_done, IDLE with no further fifo_rd.
// - Timeout: uart_tx_done never pulses -> tx_timeout_err=1 exactly TX_TIMEOUT cycles after start; stays 1; next stream served.
// - Header (STREAM_HEADER_EN): stream 3 data 8'h5A -> starts carry 8'hA3 then 8'h5A; without the macro, only 8'h5A.

Source files
------------

// File: rtl/stream_tx_scheduler.sv
// -----------------------------------------------------------------------------
// stream_tx_scheduler
//
// Round-robin scheduler that drains per-sensor byte FIFOs into one shared UART
// transmitter. It moves one byte per grant and keeps at most one FIFO read and
// one UART transaction in flight.
//
// Optional feature macro: STREAM_HEADER_EN
//   When it is defined, each data byte is preceded by a header byte
//   {5'b10100, stream index} sent with the same ready/start/done/timeout
//   handshake. If the header times out, the data byte is dropped.
//   When it is undefined, only data bytes are sent.
//
// Ports
//   clock            in   system clock; all state changes on posedge
//   resetn           in   asynchronous active-low reset
//   ds_sending_flag  in   1 = streaming enabled
//   stream_select    in   per-stream enable mask
//   fifo_empty       in   per-stream FIFO empty flags
//   fifo_data        in   FIFO i read data on [8i+7:8i], valid the cycle after read
//   fifo_rd          out  one-hot, one-cycle FIFO read strobe
//   uart_tx_ready    in   transmitter idle
//   uart_tx_done     in   one-cycle pulse when the byte has been shifted out
//   uart_tx_start    out  one-cycle pulse; transmitter latches uart_tx_byte
//   uart_tx_byte     out  byte being transmitted, stable from start to done
//   current_stream   out  index of the stream being served
//   busy             out  high in every state except IDLE
//   tx_timeout_err   out  sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module stream_tx_scheduler #(
  parameter int NUM_STREAMS = 8,
  parameter int TX_TIMEOUT  = 1023,
  localparam int IDX_W      = $clog2(NUM_STREAMS),
  localparam int TMR_W      = $clog2(TX_TIMEOUT + 1)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     ds_sending_flag,
  input  logic [NUM_STREAMS-1:0]   stream_select,
  input  logic [NUM_STREAMS-1:0]   fifo_empty,
  input  logic [8*NUM_STREAMS-1:0] fifo_data,
  output logic [NUM_STREAMS-1:0]   fifo_rd,
  input  logic                     uart_tx_ready,
  input  logic                     uart_tx_done,
  output logic                     uart_tx_start,
  output logic [7:0]               uart_tx_byte,
  output logic [IDX_W-1:0]         current_stream,
  output logic                     busy,
  output logic                     tx_timeout_err
);

`ifdef STREAM_HEADER_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_READ, S_CAPTURE, S_SEND, S_WAIT_DONE, S_HDR_SEND, S_HDR_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_READ, S_CAPTURE, S_SEND, S_WAIT_DONE
  } state_t;
`endif

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         r_last;
  logic [7:0]               r_tx_byte;
  logic [TMR_W-1:0]         r_timer;
  logic                     r_err;

  logic [NUM_STREAMS-1:0]   w_eligible;
  logic [IDX_W-1:0]         w_sel_idx;
  logic [IDX_W-1:0]         w_cand;
  logic [7:0]               w_cap_byte;
  logic [NUM_STREAMS-1:0]   w_fifo_rd;
  logic                     w_tx_start;
  logic                     w_latch_idx;
  logic                     w_capture;
  logic                     w_clr_timer;
  logic                     w_timing;
  logic                     w_set_err;
  logic                     w_finish;
  logic                     w_expired;

  assign w_eligible = stream_select & ~fifo_empty;
  assign w_expired  = (r_timer == TMR_W'(TX_TIMEOUT - 1));

  // Round-robin search starting just after the last served stream. The loop
  // runs from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = NUM_STREAMS; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_STREAMS);
      if (w_eligible[w_cand]) w_sel_idx = w_cand;
    end
  end

  // Byte lane of the granted FIFO. A constant-index mux avoids a variable part-select.
  always_comb begin
    w_cap_byte = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (r_idx == IDX_W'(i)) w_cap_byte = fifo_data[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = '0;
    w_tx_start  = 1'b0;
    w_latch_idx = 1'b0;
    w_capture   = 1'b0;
    w_clr_timer = 1'b0;
    w_timing    = 1'b0;
    w_set_err   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ds_sending_flag && (|w_eligible)) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        // Nothing has been popped yet, so a dropped flag or vanished
        // eligibility can still abort cleanly.
        if (!ds_sending_flag || !(|w_eligible)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_latch_idx = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_fifo_rd[r_idx] = 1'b1;
        w_state_nxt      = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
`ifdef STREAM_HEADER_EN
        w_state_nxt = S_HDR_SEND;
`else
        w_state_nxt = S_SEND;
`endif
      end
      S_SEND: begin
        if (uart_tx_ready) begin
          w_tx_start  = 1'b1;
          w_clr_timer = 1'b1;
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        w_timing = 1'b1;
        // done is checked first so a done arriving on the expiry cycle is not an error
        if (uart_tx_done) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expired) begin
          w_set_err   = 1'b1;
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef STREAM_HEADER_EN
      S_HDR_SEND: begin
        if (uart_tx_ready) begin
          w_tx_start  = 1'b1;
          w_clr_timer = 1'b1;
          w_state_nxt = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        w_timing = 1'b1;
        if (uart_tx_done) begin
          w_state_nxt = S_SEND;
        end else if (w_expired) begin
          // the captured data byte is abandoned along with the header
          w_set_err   = 1'b1;
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_last    <= IDX_W'(NUM_STREAMS - 1);
      r_tx_byte <= '0;
      r_timer   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_idx) r_idx <= w_sel_idx;
      if (w_capture)   r_tx_byte <= w_cap_byte;
      if (w_clr_timer)   r_timer <= '0;
      else if (w_timing) r_timer <= r_timer + TMR_W'(1);
      if (w_set_err)   r_err  <= 1'b1;
      if (w_finish)    r_last <= r_idx;
    end
  end

  assign fifo_rd        = w_fifo_rd;
  assign uart_tx_start  = w_tx_start;
  assign current_stream = r_idx;
  assign busy           = (r_state != S_IDLE);
  assign tx_timeout_err = r_err;

`ifdef STREAM_HEADER_EN
  assign uart_tx_byte = ((r_state == S_HDR_SEND) || (r_state == S_HDR_WAIT))
                        ? {5'b10100, r_idx} : r_tx_byte;
`else
  assign uart_tx_byte = r_tx_byte;
`endif

endmodule
